// File: rtl/cpu_pkg.sv
// Shared CPU-core constants and types for the register file and its scoreboard.
package cpu_pkg;

   localparam int unsigned NUM_REGISTERS           = 32;
   localparam int unsigned DATA_WIDTH              = 32;
   localparam int unsigned PENDING_WIDTH           = 2;
   localparam int unsigned REGISTER_INDEXING_WIDTH = $clog2(NUM_REGISTERS);

   typedef logic [REGISTER_INDEXING_WIDTH-1:0] reg_index_t;
   typedef logic [PENDING_WIDTH-1:0]           pending_t;
   typedef logic [DATA_WIDTH-1:0]              data_t;

   localparam pending_t PENDING_MAX = '1;

endpackage

// File: rtl/register_scoreboard.sv
// Per-register pending-write counters: decode reserves destinations, writeback releases them.
module register_scoreboard
   import cpu_pkg::*;
(
   input  logic                               clk_i,
   input  logic                               rst_i,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] reserve_register_i,
   input  logic                               reserve_activate_i,
   output logic                               reserve_ready_o,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register_i,
   input  logic                               write_activate_i,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] query_a_i,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] query_b_i,
   output logic                               busy_a_o,
   output logic                               busy_b_o,
   output logic                               underflow_error_o
);

   pending_t cnt_q [NUM_REGISTERS];
   pending_t cnt_d [NUM_REGISTERS];
   logic     underflow_q, underflow_d;
   logic     reserve_fire, release_ok;

   // Busy drops in the same cycle as the final release so it lines up with the data bypass.
   function automatic logic calc_busy(input reg_index_t idx);
      logic final_release;
      final_release = write_activate_i && (write_register_i == idx) && (cnt_q[idx] == pending_t'(1));
      return !rst_i && (idx != '0) && (cnt_q[idx] != '0) && !final_release;
   endfunction

   always_comb begin
      reserve_ready_o = !rst_i && ((reserve_register_i == '0) ||
                                   (cnt_q[reserve_register_i] != PENDING_MAX));
      busy_a_o        = calc_busy(query_a_i);
      busy_b_o        = calc_busy(query_b_i);
      reserve_fire    = reserve_activate_i && reserve_ready_o && (reserve_register_i != '0);
      release_ok      = write_activate_i && (write_register_i != '0) &&
                        (cnt_q[write_register_i] != '0);
   end

   always_comb begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
         cnt_d[r] = cnt_q[r];
      end
      underflow_d = underflow_q;
      if (reserve_fire) begin
         cnt_d[reserve_register_i] = cnt_d[reserve_register_i] + pending_t'(1);
      end
      if (release_ok) begin
         cnt_d[write_register_i] = cnt_d[write_register_i] - pending_t'(1);
      end
      if (write_activate_i && (write_register_i != '0) && (cnt_q[write_register_i] == '0)) begin
         underflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            cnt_q[r] <= '0;
         end
         underflow_q <= 1'b0;
      end else begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
         underflow_q <= underflow_d;
      end
   end

   assign underflow_error_o = underflow_q;

endmodule

// File: rtl/register_file.sv
// Architectural integer register file with two bypassed read ports and a write scoreboard.
module register_file
   import cpu_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_a,
   output logic [DATA_WIDTH-1:0]              read_data_a,
   output logic                               read_busy_a,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] read_register_b,
   output logic [DATA_WIDTH-1:0]              read_data_b,
   output logic                               read_busy_b,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] reserve_register,
   input  logic                               reserve_activate,
   output logic                               reserve_ready,
   input  logic [REGISTER_INDEXING_WIDTH-1:0] write_register,
   input  logic [DATA_WIDTH-1:0]              write_data,
   input  logic                               write_activate,
   output logic                               underflow_error
);

   data_t regs_q [NUM_REGISTERS];
   data_t regs_d [NUM_REGISTERS];

   function automatic data_t read_port(input reg_index_t idx);
      if (rst || (idx == '0)) begin
         return '0;
      end else if (write_activate && (write_register == idx)) begin
         return write_data;
      end
      return regs_q[idx];
   endfunction

   always_comb begin
      for (int r = 0; r < NUM_REGISTERS; r++) begin
         regs_d[r] = regs_q[r];
      end
      if (write_activate && (write_register != '0)) begin
         regs_d[write_register] = write_data;
      end
      read_data_a = read_port(read_register_a);
      read_data_b = read_port(read_register_b);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            regs_q[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGISTERS; r++) begin
            regs_q[r] <= regs_d[r];
         end
      end
   end

   register_scoreboard u_scoreboard (
      .clk_i              (clk),
      .rst_i              (rst),
      .reserve_register_i (reserve_register),
      .reserve_activate_i (reserve_activate),
      .reserve_ready_o    (reserve_ready),
      .write_register_i   (write_register),
      .write_activate_i   (write_activate),
      .query_a_i          (read_register_a),
      .query_b_i          (read_register_b),
      .busy_a_o           (read_busy_a),
      .busy_b_o           (read_busy_b),
      .underflow_error_o  (underflow_error)
   );

endmodule

// File: tb/tb_register_file.sv
// Directed, table-driven bench for register_file; each row is one clock cycle.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  read_register_a, read_register_b, reserve_register, write_register;
   logic [31:0] read_data_a, read_data_b, write_data;
   logic        read_busy_a, read_busy_b, reserve_activate, reserve_ready;
   logic        write_activate, underflow_error;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   register_file dut (
      .clk              (clk),
      .rst              (rst),
      .read_register_a  (read_register_a),
      .read_data_a      (read_data_a),
      .read_busy_a      (read_busy_a),
      .read_register_b  (read_register_b),
      .read_data_b      (read_data_b),
      .read_busy_b      (read_busy_b),
      .reserve_register (reserve_register),
      .reserve_activate (reserve_activate),
      .reserve_ready    (reserve_ready),
      .write_register   (write_register),
      .write_data       (write_data),
      .write_activate   (write_activate),
      .underflow_error  (underflow_error)
   );

   typedef struct {
      logic        rst;
      logic [4:0]  ra, rb, rr;
      logic        ract;
      logic [4:0]  wr;
      logic [31:0] wd;
      logic        wact;
      logic [31:0] exp_da;
      logic        exp_ba;
      logic [31:0] exp_db;
      logic        exp_bb;
      logic        exp_rdy;
      logic        exp_uf;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [4:0] rr, input logic ract, input logic [4:0] wr,
                      input logic [31:0] wd, input logic wact, input logic [31:0] da,
                      input logic ba, input logic [31:0] db, input logic bb,
                      input logic rdy, input logic uf);
      vec_t v;
      v.rst = r; v.ra = ra; v.rb = rb; v.rr = rr; v.ract = ract; v.wr = wr; v.wd = wd;
      v.wact = wact; v.exp_da = da; v.exp_ba = ba; v.exp_db = db; v.exp_bb = bb;
      v.exp_rdy = rdy; v.exp_uf = uf;
      vecs.push_back(v);
   endtask

   initial begin
      rst = 1'b1; read_register_a = '0; read_register_b = '0; reserve_register = '0;
      reserve_activate = 1'b0; write_register = '0; write_data = '0; write_activate = 1'b0;

      //   rst ra  rb  rr  ract wr  wd            wact da            ba db            bb rdy uf
      // reset: everything quiet and activity ignored
      add(1, 1,  1,  3,  1,   1,  32'hAAAA,     1,   32'h0,        0, 32'h0,        0, 0,  0);
      add(0, 1,  31, 0,  0,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);
      // write to x0 is dropped and never bypassed
      add(0, 0,  0,  0,  0,   0,  32'hDEAD,     1,   32'h0,        0, 32'h0,        0, 1,  0);
      add(0, 0,  1,  0,  0,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);
      // reserve x5, then write with bypass
      add(0, 5,  0,  5,  1,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);
      add(0, 5,  5,  0,  0,   5,  32'h1234,     1,   32'h1234,     0, 32'h1234,     0, 1,  0);
      add(0, 5,  1,  0,  0,   0,  32'h0,        0,   32'h1234,     0, 32'h0,        0, 1,  0);
      // reserve x7 up to saturation, then a refused reserve
      add(0, 7,  0,  7,  1,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);
      add(0, 7,  0,  7,  1,   0,  32'h0,        0,   32'h0,        1, 32'h0,        0, 1,  0);
      add(0, 7,  0,  7,  1,   0,  32'h0,        0,   32'h0,        1, 32'h0,        0, 1,  0);
      add(0, 7,  0,  7,  1,   0,  32'h0,        0,   32'h0,        1, 32'h0,        0, 0,  0);
      add(0, 7,  7,  7,  1,   0,  32'h0,        0,   32'h0,        1, 32'h0,        1, 0,  0);
      // release x7 three times; ready keeps its pre-release value
      add(0, 7,  0,  7,  0,   7,  32'h71,       1,   32'h71,       1, 32'h0,        0, 0,  0);
      add(0, 7,  0,  0,  0,   7,  32'h72,       1,   32'h72,       1, 32'h0,        0, 1,  0);
      add(0, 7,  7,  0,  0,   7,  32'h73,       1,   32'h73,       0, 32'h73,       0, 1,  0);
      add(0, 7,  7,  7,  0,   0,  32'h0,        0,   32'h73,       0, 32'h73,       0, 1,  0);
      // x9: simultaneous reserve and release keeps the count at 1
      add(0, 9,  0,  9,  1,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);
      add(0, 9,  0,  9,  1,   9,  32'h99,       1,   32'h99,       0, 32'h0,        0, 1,  0);
      add(0, 9,  9,  0,  0,   0,  32'h0,        0,   32'h99,       1, 32'h99,       1, 1,  0);
      add(0, 9,  0,  0,  0,   9,  32'h9A,       1,   32'h9A,       0, 32'h0,        0, 1,  0);
      add(0, 9,  0,  9,  0,   0,  32'h0,        0,   32'h9A,       0, 32'h0,        0, 1,  0);
      // underflow on x4: data still written, flag sticky
      add(0, 4,  0,  0,  0,   4,  32'h44,       1,   32'h44,       0, 32'h0,        0, 1,  0);
      add(0, 4,  9,  0,  0,   0,  32'h0,        0,   32'h44,       0, 32'h9A,       0, 1,  1);
      add(0, 0,  4,  0,  0,   0,  32'h0,        0,   32'h0,        0, 32'h44,       0, 1,  1);
      // x3 in flight when reset arrives
      add(0, 3,  0,  3,  1,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  1);
      add(0, 3,  4,  0,  0,   0,  32'h0,        0,   32'h0,        1, 32'h44,       0, 1,  1);
      add(1, 3,  4,  3,  1,   4,  32'h55,       1,   32'h0,        0, 32'h0,        0, 0,  1);
      add(0, 3,  4,  3,  0,   0,  32'h0,        0,   32'h0,        0, 32'h0,        0, 1,  0);

      foreach (vecs[i]) begin
         rst              = vecs[i].rst;
         read_register_a  = vecs[i].ra;
         read_register_b  = vecs[i].rb;
         reserve_register = vecs[i].rr;
         reserve_activate = vecs[i].ract;
         write_register   = vecs[i].wr;
         write_data       = vecs[i].wd;
         write_activate   = vecs[i].wact;
         @(negedge clk);
         check($sformatf("v%0d.data_a", i), read_data_a, vecs[i].exp_da);
         check($sformatf("v%0d.busy_a", i), 32'(read_busy_a), 32'(vecs[i].exp_ba));
         check($sformatf("v%0d.data_b", i), read_data_b, vecs[i].exp_db);
         check($sformatf("v%0d.busy_b", i), 32'(read_busy_b), 32'(vecs[i].exp_bb));
         check($sformatf("v%0d.ready", i), 32'(reserve_ready), 32'(vecs[i].exp_rdy));
         check($sformatf("v%0d.underflow", i), 32'(underflow_error), 32'(vecs[i].exp_uf));
         @(posedge clk);
         #1;
      end

      // After the mid-flight reset every register reads back zero and idle.
      reserve_activate = 1'b0;
      write_activate   = 1'b0;
      for (int r = 1; r < 32; r++) begin
         read_register_a = 5'(r);
         read_register_b = 5'(32 - r);
         #1;
         check($sformatf("post_rst.x%0d.data", r), read_data_a, 32'h0);
         check($sformatf("post_rst.x%0d.busy", r), 32'(read_busy_a), 32'h0);
         check($sformatf("post_rst.x%0d.data_b", r), read_data_b, 32'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
